// File: rtl/hdb3_bnzs_encoder_if.sv
// Stream bundle for hdb3_bnzs_encoder: NRZ input side plus bipolar P/N output side.
// ami_mode exists only when HDB3_AMI_MODE_EN is defined.
interface hdb3_bnzs_encoder_if;
  logic in_valid;
  logic din;
  logic out_valid;
  logic pos;
  logic neg;
  logic sub_event;
`ifdef HDB3_AMI_MODE_EN
  logic ami_mode;

  modport master (output in_valid, din, ami_mode, input out_valid, pos, neg, sub_event);
  modport slave  (input in_valid, din, ami_mode, output out_valid, pos, neg, sub_event);
`else
  modport master (output in_valid, din, input out_valid, pos, neg, sub_event);
  modport slave  (input in_valid, din, output out_valid, pos, neg, sub_event);
`endif
endinterface

// File: rtl/hdb3_bnzs_encoder.sv
// hdb3_bnzs_encoder: BnZS / HDB3 zero-substitution line encoder.
// ZERO_RUN=4 gives HDB3, ZERO_RUN=3 gives B3ZS. Stage 1 classifies each
// accepted bit into a ZERO_RUN-deep delay line (with retroactive B rewrite),
// stage 2 assigns AMI polarity at the delay-line exit.
// Optional macro HDB3_AMI_MODE_EN adds bus.ami_mode (plain AMI, no substitution).
module hdb3_bnzs_encoder #(
  parameter int ZERO_RUN = 4,
  parameter int CNT_W    = 3
) (
  input logic                  clk,
  input logic                  reset,
  hdb3_bnzs_encoder_if.slave   bus
);

  localparam int PW = $clog2(ZERO_RUN + 1);

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_MARK = 2'd1,
    SYM_V    = 2'd2,
    SYM_B    = 2'd3
  } sym_t;

  sym_t             dl [ZERO_RUN];
  sym_t             cls;
  sym_t             exit_sym;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             parity;
  logic             parity_nxt;
  logic             rewrite_b;
  logic             subst_en;
  logic [PW-1:0]    prime;
  logic             primed;
  logic             last_pol;   // 0 = negative, 1 = positive
  logic             accept;

`ifdef HDB3_AMI_MODE_EN
  logic ami_prev;
`endif

  assign accept   = bus.in_valid;
  assign exit_sym = dl[ZERO_RUN-1];
  assign primed   = (prime == PW'(ZERO_RUN));

  // Stage 1 classification of the incoming bit
  always_comb begin
    cls        = SYM_ZERO;
    cnt_nxt    = cnt;
    parity_nxt = parity;
    rewrite_b  = 1'b0;
    subst_en   = 1'b1;
`ifdef HDB3_AMI_MODE_EN
    subst_en   = !(bus.ami_mode || (bus.ami_mode != ami_prev));
`endif
    if (!subst_en) begin
      cls        = bus.din ? SYM_MARK : SYM_ZERO;
      cnt_nxt    = '0;
      parity_nxt = 1'b0;
    end else if (bus.din) begin
      cls        = SYM_MARK;
      cnt_nxt    = '0;
      parity_nxt = ~parity;
    end else if (cnt == CNT_W'(ZERO_RUN - 1)) begin
      cls        = SYM_V;
      cnt_nxt    = '0;
      parity_nxt = 1'b0;
      rewrite_b  = ~parity;
    end else begin
      cls        = SYM_ZERO;
      cnt_nxt    = cnt + CNT_W'(1);
    end
  end

  // Zero counter, pulse parity and priming counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      parity   <= 1'b0;
      prime    <= '0;
`ifdef HDB3_AMI_MODE_EN
      ami_prev <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= cnt_nxt;
      parity <= parity_nxt;
      if (!primed) prime <= prime + PW'(1);
`ifdef HDB3_AMI_MODE_EN
      ami_prev <= bus.ami_mode;
`endif
    end
  end

  // Delay line shift; an even-parity V rewrites the oldest zero of its run
  // (which lands in the last slot after this shift) to B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ZERO_RUN; i++) dl[i] <= SYM_ZERO;
    end else if (accept) begin
      for (int unsigned i = 1; i < ZERO_RUN; i++) dl[i] <= dl[i-1];
      dl[0] <= cls;
      if (rewrite_b) dl[ZERO_RUN-1] <= SYM_B;
    end
  end

  // Stage 2 polarity assignment at the delay-line exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.sub_event <= 1'b0;
      bus.pos       <= 1'b0;
      bus.neg       <= 1'b0;
      last_pol      <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= primed;
      bus.sub_event <= primed && (exit_sym == SYM_V);
      if (primed) begin
        case (exit_sym)
          SYM_MARK, SYM_B: begin
            bus.pos  <= ~last_pol;
            bus.neg  <= last_pol;
            last_pol <= ~last_pol;
          end
          SYM_V: begin
            bus.pos <= last_pol;
            bus.neg <= ~last_pol;
          end
          default: begin
            bus.pos <= 1'b0;
            bus.neg <= 1'b0;
          end
        endcase
      end
    end else begin
      bus.out_valid <= 1'b0;
      bus.sub_event <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdb3_bnzs_encoder.sv
// Directed bench for hdb3_bnzs_encoder: HDB3 (ZERO_RUN=4) and B3ZS (ZERO_RUN=3)
// instances, hand-computed symbol sequences, idle-cycle hold and reset behaviour.
module tb_hdb3_bnzs_encoder;

  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] Z = 2'b00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hdb3_bnzs_encoder_if b4 ();
  hdb3_bnzs_encoder_if b3 ();

  hdb3_bnzs_encoder #(.ZERO_RUN(4), .CNT_W(3)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  hdb3_bnzs_encoder #(.ZERO_RUN(3), .CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  int tests_run = 0;
  int tests_failed = 0;
  int sel = 4;
  int k = 0;
  logic [1:0] exp_sym [$];
  logic       exp_sub [$];
  logic       bits [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(output logic ov, output logic p, output logic n, output logic se);
    if (sel == 3) begin
      ov = b3.out_valid; p = b3.pos; n = b3.neg; se = b3.sub_event;
    end else begin
      ov = b4.out_valid; p = b4.pos; n = b4.neg; se = b4.sub_event;
    end
  endtask

  task automatic step(input logic b, input logic v);
    logic ov, p, n, se;
    logic [1:0] hold;
    @(negedge clk);
    b3.in_valid = 1'b0;
    b4.in_valid = 1'b0;
    if (sel == 3) begin
      b3.din = b; b3.in_valid = v;
    end else begin
      b4.din = b; b4.in_valid = v;
    end
    @(posedge clk);
    #1;
    sample(ov, p, n, se);
    if (ov) begin
      if (k < exp_sym.size()) begin
        check($sformatf("sym%0d", k), {30'd0, p, n}, {30'd0, exp_sym[k]});
        check($sformatf("sub%0d", k), {31'd0, se}, {31'd0, exp_sub[k]});
      end else begin
        check("extra_sym", {31'd0, ov}, 32'd0);
      end
      k++;
    end else begin
      hold = (k > 0 && k <= exp_sym.size()) ? exp_sym[k-1] : Z;
      check("hold", {30'd0, p, n}, {30'd0, hold});
      check("sub_idle", {31'd0, se}, 32'd0);
    end
  endtask

  task automatic do_reset();
    logic ov, p, n, se;
    @(negedge clk);
    b3.in_valid = 1'b0;
    b4.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    sample(ov, p, n, se);
    check("rst_outs", {28'd0, ov, p, n, se}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic begin_test(input int s);
    sel = s;
    k = 0;
    exp_sym.delete();
    exp_sub.delete();
    do_reset();
  endtask

  task automatic run_bits(input logic idle_between);
    foreach (bits[i]) begin
      step(bits[i], 1'b1);
      if (idle_between) step(~bits[i], 1'b0);
    end
  endtask

  task automatic end_test(input string tag);
    check(tag, k, exp_sym.size());
  endtask

  initial begin
    b3.in_valid = 1'b0; b3.din = 1'b0;
    b4.in_valid = 1'b0; b4.din = 1'b0;
`ifdef HDB3_AMI_MODE_EN
    b3.ami_mode = 1'b0;
    b4.ami_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // HDB3: mark then 8 zeros -> 000V then B00V
    begin_test(4);
    exp_sym = '{P, Z, Z, Z, P, M, Z, Z, M};
    exp_sub = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    bits = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_t1");

    // HDB3: 4 zeros at start with even parity -> B00V, then marks
    begin_test(4);
    exp_sym = '{P, Z, Z, P, M, P, M, P};
    exp_sub = '{0, 0, 0, 1, 0, 0, 0, 0};
    bits = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_t2");

    // All ones -> plain alternation
    begin_test(4);
    exp_sym = '{P, M, P, M, P, M, P, M};
    exp_sub = '{0, 0, 0, 0, 0, 0, 0, 0};
    bits = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_t3");

    // First stimulus with idle cycles interleaved; outputs must hold
    begin_test(4);
    exp_sym = '{P, Z, Z, Z, P, M, Z, Z, M};
    exp_sub = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    bits = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    run_bits(1'b1);
    end_test("count_t4");

    // Reset mid-run discards the partial run
    begin_test(4);
    bits = '{1, 0, 0, 0};
    run_bits(1'b0);
    do_reset();
    exp_sym = '{Z};
    exp_sub = '{0};
    bits = '{0, 1, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_t5");

    // B3ZS: mark then 6 zeros -> 00V then B0V
    begin_test(3);
    exp_sym = '{P, Z, Z, P, M, Z, M};
    exp_sub = '{0, 0, 0, 1, 0, 0, 1};
    bits = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_t6");

`ifdef HDB3_AMI_MODE_EN
    // AMI mode: no substitution at all
    b4.ami_mode = 1'b1;
    begin_test(4);
    exp_sym = '{P, Z, Z, Z, Z, Z, Z, Z, Z};
    exp_sub = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    bits = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    run_bits(1'b0);
    end_test("count_ami");
    b4.ami_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
